// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//
// Bundles the two streams of the RV32I instruction encoder:
//   * record side : in_valid / in_ready plus the decoded fields
//                   (fmt, opcode, rd, funct3, rs1, rs2, funct7, imm)
//   * word side   : out_valid / out_ready plus out_instr and out_addr
//   * status      : word_count (words emitted) and the sticky err flag
//
// Modports:
//   master - the producer/consumer side (program loader, testbench)
//   slave  - the encoder itself
// ---------------------------------------------------------------------------
interface instr_encoder_if;

   // Record stream into the encoder
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] imm;

   // Word stream out of the encoder
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;

   // Status
   logic [15:0] word_count;
   logic        err;

   // The side that feeds records and drains words
   modport master (
      output in_valid,
      output fmt,
      output opcode,
      output rd,
      output funct3,
      output rs1,
      output rs2,
      output funct7,
      output imm,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_instr,
      input  out_addr,
      input  word_count,
      input  err
   );

   // The encoder's view of the same wires
   modport slave (
      input  in_valid,
      input  fmt,
      input  opcode,
      input  rd,
      input  funct3,
      input  rs1,
      input  rs2,
      input  funct7,
      input  imm,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_instr,
      output out_addr,
      output word_count,
      output err
   );

endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Sequential RV32I instruction encoder. Decoded field records arrive on a
// valid/ready handshake, are packed into 32-bit instruction words and are
// buffered in a small FIFO. Words leave on a second valid/ready stream, each
// tagged with a sequential byte address starting at BASE_ADDR.
//
// Parameters:
//   DEPTH     - FIFO entries, power of two in 2..16
//   BASE_ADDR - address of the first word after reset or restart
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   restart - synchronous flush: empties the FIFO, reloads the address,
//             clears word_count and err, drops the record in flight
//   bus     - instr_encoder_if.slave (record stream, word stream, status)
//
// Optional feature macro:
//   ENC_IMM_CHECK_EN - when defined, every immediate is checked for being
//                      representable in its format; a violation still pushes
//                      the truncated word but raises err.
// ---------------------------------------------------------------------------
module instr_encoder #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           restart,
   instr_encoder_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   // Storage and bookkeeping state
   logic [31:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      addr_q, addr_d;
   logic [15:0]      word_count_q, word_count_d;
   logic             err_q, err_d;

   // Handshake and packing signals
   logic        fifo_full;
   logic        fifo_empty;
   logic        accept;
   logic        fmt_legal;
   logic        push;
   logic        pop;
   logic        imm_bad;
   logic [31:0] packed_word;

   // Handshake decode. in_ready only looks at occupancy, so a full FIFO
   // refuses a record even when a pop happens in the same cycle. restart
   // wins over both handshakes: the record in flight and the head word are
   // both left alone while everything is flushed.
   always_comb begin
      fifo_full  = (count_q == FULL_COUNT);
      fifo_empty = (count_q == '0);
      fmt_legal  = (bus.fmt <= FMT_J);
      accept     = bus.in_valid && !fifo_full && !restart;
      push       = accept && fmt_legal;
      pop        = !fifo_empty && bus.out_ready && !restart;
   end

   // Field-to-word packing. Each format scatters the immediate into its own
   // bit positions; fields a format does not use simply never appear. The
   // I-format shift-immediates need no special case because the caller puts
   // funct7 into imm[11:5] already.
   always_comb begin
      packed_word = '0;
      case (bus.fmt)
         FMT_R: packed_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3,
                               bus.rd, bus.opcode};
         FMT_I: packed_word = {bus.imm[11:0], bus.rs1, bus.funct3,
                               bus.rd, bus.opcode};
         FMT_S: packed_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                               bus.imm[4:0], bus.opcode};
         FMT_B: packed_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1,
                               bus.funct3, bus.imm[4:1], bus.imm[11],
                               bus.opcode};
         FMT_U: packed_word = {bus.imm[31:12], bus.rd, bus.opcode};
         FMT_J: packed_word = {bus.imm[20], bus.imm[10:1], bus.imm[11],
                               bus.imm[19:12], bus.rd, bus.opcode};
         default: packed_word = '0;
      endcase
   end

`ifdef ENC_IMM_CHECK_EN
   // Range check of the immediate. A value fits when every bit above the
   // format's sign bit is a copy of it; branch and jump offsets must also be
   // even, and U-type values must have nothing in the low twelve bits.
   always_comb begin
      imm_bad = 1'b0;
      case (bus.fmt)
         FMT_I, FMT_S:
            imm_bad = !((&bus.imm[31:11]) || !(|bus.imm[31:11]));
         FMT_B:
            imm_bad = !((&bus.imm[31:12]) || !(|bus.imm[31:12])) || bus.imm[0];
         FMT_J:
            imm_bad = !((&bus.imm[31:20]) || !(|bus.imm[31:20])) || bus.imm[0];
         FMT_U:
            imm_bad = (bus.imm[11:0] != 12'h000);
         default:
            imm_bad = 1'b0;
      endcase
   end
`else
   // Without the range check only an illegal format can raise err.
   assign imm_bad = 1'b0;
`endif

   // Next-state logic for the FIFO pointers, occupancy, address counter,
   // word counter and sticky error flag. Pointers wrap naturally because
   // DEPTH is a power of two. A simultaneous push and pop leaves the
   // occupancy unchanged while both pointers advance, which keeps order.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      addr_d       = addr_q;
      word_count_d = word_count_q;
      err_d        = err_q;

      if (restart) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         addr_d       = BASE_ADDR;
         word_count_d = '0;
         err_d        = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            addr_d   = addr_q + 32'd4;
            if (word_count_q != 16'hFFFF) begin
               word_count_d = word_count_q + 16'd1;
            end
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (accept && (!fmt_legal || imm_bad)) begin
            err_d = 1'b1;
         end
      end
   end

   // Control state registers. Reset puts the encoder back to an empty FIFO
   // at BASE_ADDR with no error; any buffered words are lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         addr_q       <= BASE_ADDR;
         word_count_q <= '0;
         err_q        <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         addr_q       <= addr_d;
         word_count_q <= word_count_d;
         err_q        <= err_d;
      end
   end

   // FIFO storage. Entries need no reset because out_instr is masked
   // whenever the FIFO is empty, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= packed_word;
      end
   end

   // Outputs come straight from registered state, so nothing on the record
   // side reaches the word side within a cycle.
   always_comb begin
      bus.in_ready   = !fifo_full;
      bus.out_valid  = !fifo_empty;
      bus.out_instr  = fifo_empty ? 32'h0000_0000 : mem_q[rd_ptr_q];
      bus.out_addr   = addr_q;
      bus.word_count = word_count_q;
      bus.err        = err_q;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. Records are issued by the main
// process; the expected word for each accepted record is queued, and a
// separate monitor pops and compares on every output handshake. Random
// records are predicted by a reference encoder that builds each word with
// plain arithmetic from the RV32I field layout.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

   localparam int unsigned DEPTH     = 4;
   localparam logic [31:0] BASE_ADDR = 32'h0000_1000;

`ifdef ENC_IMM_CHECK_EN
   localparam logic IMM_CHK = 1'b1;
`else
   localparam logic IMM_CHK = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic restart;

   instr_encoder_if bus ();

   instr_encoder #(
      .DEPTH    (DEPTH),
      .BASE_ADDR(BASE_ADDR)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .restart(restart),
      .bus    (bus)
   );

   // Scoreboard state
   logic [31:0] exp_q[$];
   logic [31:0] exp_addr;
   int          exp_words;
   logic        err_exp;
   int          total;
   int          bad;
   int          ready_mode;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog: a hung bench still reports before stopping.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // out_ready driver: 0 = held low, 1 = held high, 2 = random per cycle.
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (ready_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
         else bus.out_ready = (ready_mode == 1);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
      end
   endtask

   // Reference model helpers
   function automatic longint bits(input logic [31:0] v, input int hi, input int lo);
      return (longint'(v) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
   endfunction

   function automatic longint pw(input int n);
      return longint'(1) << n;
   endfunction

   function automatic logic [31:0] modelEncode(input int f, input int op,
         input int rd_v, input int f3, input int rs1_v, input int rs2_v,
         input int f7, input logic [31:0] imm_v);
      longint w;
      longint base_rs;
      base_rs = longint'(rs1_v) * pw(15) + longint'(f3) * pw(12) + longint'(op);
      case (f)
         0: w = longint'(f7) * pw(25) + longint'(rs2_v) * pw(20) + base_rs
                + longint'(rd_v) * pw(7);
         1: w = bits(imm_v, 11, 0) * pw(20) + base_rs + longint'(rd_v) * pw(7);
         2: w = bits(imm_v, 11, 5) * pw(25) + longint'(rs2_v) * pw(20) + base_rs
                + bits(imm_v, 4, 0) * pw(7);
         3: w = bits(imm_v, 12, 12) * pw(31) + bits(imm_v, 10, 5) * pw(25)
                + longint'(rs2_v) * pw(20) + base_rs + bits(imm_v, 4, 1) * pw(8)
                + bits(imm_v, 11, 11) * pw(7);
         4: w = bits(imm_v, 31, 12) * pw(12) + longint'(rd_v) * pw(7) + longint'(op);
         5: w = bits(imm_v, 20, 20) * pw(31) + bits(imm_v, 10, 1) * pw(21)
                + bits(imm_v, 11, 11) * pw(20) + bits(imm_v, 19, 12) * pw(12)
                + longint'(rd_v) * pw(7) + longint'(op);
         default: w = 0;
      endcase
      return w[31:0];
   endfunction

   // Representability of an immediate, judged by its signed value.
   function automatic bit immFits(input int f, input logic [31:0] imm_v);
      longint s;
      s = longint'($signed(imm_v));
      case (f)
         1, 2: return (s >= -2048) && (s <= 2047);
         3: return (s >= -4096) && (s <= 4095) && (bits(imm_v, 0, 0) == 0);
         4: return bits(imm_v, 11, 0) == 0;
         5: return (s >= -pw(20)) && (s < pw(20)) && (bits(imm_v, 0, 0) == 0);
         default: return 1'b1;
      endcase
   endfunction

   // Drive one record and hold it until accepted (bounded). Entered and left
   // one time unit after a rising edge.
   task automatic applyStimulus(input int f, input int op, input int rd_v,
         input int f3, input int rs1_v, input int rs2_v, input int f7,
         input logic [31:0] imm_v, input logic [31:0] exp_word);
      bit done;
      done = 1'b0;
      bus.fmt    = 3'(f);
      bus.opcode = 7'(op);
      bus.rd     = 5'(rd_v);
      bus.funct3 = 3'(f3);
      bus.rs1    = 5'(rs1_v);
      bus.rs2    = 5'(rs2_v);
      bus.funct7 = 7'(f7);
      bus.imm    = imm_v;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (bus.in_ready && !restart) begin
            done = 1'b1;
            if (f <= 5) exp_q.push_back(exp_word);
            else err_exp = 1'b1;
            if (IMM_CHK && f <= 5 && !immFits(f, imm_v)) err_exp = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic pushRandom(input bit allow_illegal);
      int f, op, rd_v, f3, rs1_v, rs2_v, f7, sel;
      logic [31:0] imm_v;
      f = $urandom_range(0, 5);
      if (allow_illegal && $urandom_range(0, 19) == 0) f = $urandom_range(6, 7);
      op = $urandom_range(0, 127); rd_v = $urandom_range(0, 31);
      f3 = $urandom_range(0, 7); rs1_v = $urandom_range(0, 31);
      rs2_v = $urandom_range(0, 31); f7 = $urandom_range(0, 127);
      sel = $urandom_range(0, 2);
      if (sel == 0) imm_v = 32'($urandom_range(0, 8191)) - 32'd4096;
      else if (sel == 1) imm_v = $urandom;
      else imm_v = $urandom & 32'hFFFF_F000;
      applyStimulus(f, op, rd_v, f3, rs1_v, rs2_v, f7, imm_v,
                    modelEncode(f, op, rd_v, f3, rs1_v, rs2_v, f7, imm_v));
   endtask

   task automatic doRestart();
      restart = 1'b1;
      @(negedge clk);
      exp_q.delete();
      exp_addr  = BASE_ADDR;
      exp_words = 0;
      err_exp   = 1'b0;
      @(posedge clk);
      #1;
      restart = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      ready_mode = 1;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput("drain_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every output handshake pops the oldest expected word.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && !restart && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_word", bus.out_instr, 32'hxxxx_xxxx);
            end else begin
               e = exp_q.pop_front();
               checkOutput("out_instr", bus.out_instr, e);
               checkOutput("out_addr", bus.out_addr, exp_addr);
               exp_addr = exp_addr + 32'd4;
               if (exp_words < 65535) exp_words++;
            end
         end
      end
   end

   initial begin
      total = 0; bad = 0; ready_mode = 0;
      exp_addr = BASE_ADDR; exp_words = 0; err_exp = 1'b0;
      rst_n = 1'b0; restart = 1'b0;
      bus.in_valid = 1'b0; bus.fmt = '0; bus.opcode = '0; bus.rd = '0;
      bus.funct3 = '0; bus.rs1 = '0; bus.rs2 = '0; bus.funct7 = '0; bus.imm = '0;

      // Reset values
      #12;
      checkOutput("rst_in_ready", bus.in_ready, 32'd1);
      checkOutput("rst_out_valid", bus.out_valid, 32'd0);
      checkOutput("rst_out_instr", bus.out_instr, 32'd0);
      checkOutput("rst_out_addr", bus.out_addr, BASE_ADDR);
      checkOutput("rst_word_count", bus.word_count, 32'd0);
      checkOutput("rst_err", bus.err, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready_mode = 1;

      // addi x1,x0,5 appears one cycle after accept
      applyStimulus(1, 7'h13, 1, 0, 0, 0, 0, 32'd5, 32'h0050_0093);
      @(negedge clk);
      checkOutput("latency_out_valid", bus.out_valid, 32'd1);
      @(posedge clk);
      #1;

      // add x3,x1,x2 ; sw x2,8(x1) ; beq x0,x0,-4 ; jal x1,8
      applyStimulus(0, 7'h33, 3, 0, 1, 2, 0, 32'd0, 32'h0020_81B3);
      applyStimulus(2, 7'h23, 0, 2, 1, 2, 0, 32'd8, 32'h0020_A423);
      waitDrain();
      checkOutput("word_count_3", bus.word_count, 32'd3);
      applyStimulus(3, 7'h63, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFE00_0EE3);
      applyStimulus(5, 7'h6F, 1, 0, 0, 0, 0, 32'd8, 32'h0080_00EF);
      waitDrain();
      checkOutput("word_count_5", bus.word_count, 32'd5);

      // Back-pressure: four records fill the FIFO
      ready_mode = 0;
      for (int i = 0; i < 4; i++) pushRandom(1'b0);
      @(negedge clk);
      checkOutput("full_in_ready", bus.in_ready, 32'd0);
      checkOutput("full_out_valid", bus.out_valid, 32'd1);
      @(posedge clk);
      #1;
      // Fifth record offered while the first pop happens: no bypass
      ready_mode = 1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      checkOutput("full_no_bypass", bus.in_ready, 32'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      pushRandom(1'b0);
      waitDrain();
      checkOutput("word_count_10", bus.word_count, 32'd10);

      // Illegal format: accepted, nothing pushed, err raised
      applyStimulus(7, 7'h13, 1, 0, 0, 0, 0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("illegal_err", bus.err, 32'd1);
      checkOutput("illegal_no_word", bus.out_valid, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("illegal_count", bus.word_count, 32'd10);

      // restart clears status and reloads the address
      doRestart();
      checkOutput("restart_err", bus.err, 32'd0);
      checkOutput("restart_word_count", bus.word_count, 32'd0);
      checkOutput("restart_addr", bus.out_addr, BASE_ADDR);
      applyStimulus(1, 7'h13, 1, 0, 0, 0, 0, 32'd5, 32'h0050_0093);
      waitDrain();

      // restart drops the record offered in the same cycle
      bus.fmt = 3'd0; bus.opcode = 7'h33; bus.in_valid = 1'b1;
      doRestart();
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("restart_drop", bus.out_valid, 32'd0);

      // Out-of-range I immediate: word is truncated, err depends on the check
      applyStimulus(1, 7'h13, 0, 0, 0, 0, 0, 32'h0000_0800, 32'h8000_0013);
      waitDrain();
      checkOutput("imm_check_err", bus.err, 32'(IMM_CHK));

      // Asynchronous reset mid-stream discards buffered words
      ready_mode = 0;
      pushRandom(1'b0);
      pushRandom(1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out_valid", bus.out_valid, 32'd0);
      checkOutput("midrst_word_count", bus.word_count, 32'd0);
      checkOutput("midrst_addr", bus.out_addr, BASE_ADDR);
      exp_q.delete();
      exp_addr = BASE_ADDR; exp_words = 0; err_exp = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Randomised traffic with random back-pressure and occasional restarts
      ready_mode = 2;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 39) == 0) doRestart();
         else if ($urandom_range(0, 5) == 0) begin
            @(posedge clk);
            #1;
         end else pushRandom(1'b1);
      end
      waitDrain();
      checkOutput("final_word_count", bus.word_count, 32'(exp_words));
      checkOutput("final_err", bus.err, 32'(err_exp));
      checkOutput("final_addr", bus.out_addr, exp_addr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
